id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 117 +++++++++++
 tb/tb_id_ex_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock and multi-cycle multiply hold.
// Optional load-use detection is enabled by defining LOAD_USE_STALL_EN.
module id_ex_stage #(
  parameter int MUL_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        InValid,
  input  logic [16:0] CtrlIn,
  input  logic [31:0] RsData,
  input  logic [31:0] RtData,
  input  logic [31:0] Imm,
  input  logic [4:0]  Rs,
  input  logic [4:0]  Rt,
  input  logic [4:0]  Rd,
  input  logic        Flush,
  output logic        Stall,
  output logic        ExBusy,
  output logic        ExValid,
  output logic [16:0] ExCtrl,
  output logic [31:0] ExRsData,
  output logic [31:0] ExRtData,
  output logic [31:0] ExImm,
  output logic [4:0]  ExRs,
  output logic [4:0]  ExRt,
  output logic [4:0]  ExRd
);

  localparam logic [4:0] OP_MUL    = 5'b01100;
  localparam logic [3:0] CNT_INIT  = 4'(MUL_CYCLES - 1);
  localparam bit         MUL_MULTI = (MUL_CYCLES > 1);

  typedef enum logic {
    RUN = 1'b0,
    MUL = 1'b1
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       busy;
  logic       load_use;
  logic       is_mul;

  assign is_mul = InValid & (CtrlIn[12:8] == OP_MUL);

`ifdef LOAD_USE_STALL_EN
  logic in_alu_src;
  logic in_mem_wr;
  logic ex_mem_rd;
  logic rs_hit;
  logic rt_hit;

  assign in_alu_src = CtrlIn[13];
  assign in_mem_wr  = CtrlIn[7];
  assign ex_mem_rd  = ExCtrl[6];
  assign rs_hit     = (Rs == ExRt);
  assign rt_hit     = (Rt == ExRt) & (~in_alu_src | in_mem_wr);

  // Load in EX whose target feeds the ID instruction.
  assign load_use = ExValid & ex_mem_rd & (ExRt != 5'd0) &
                    InValid & (rs_hit | rt_hit);
`else
  // Load delay slots are scheduled by software.
  assign load_use = 1'b0;
`endif

  // Flush overrides any hold request in the same cycle.
  assign Stall  = ~Flush & ((state == MUL) | load_use);
  assign ExBusy = busy;

  // Pipeline register, bubble insertion and multiply occupancy FSM.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= RUN;
      cnt      <= 4'd0;
      busy     <= 1'b0;
      ExValid  <= 1'b0;
      ExCtrl   <= 17'd0;
      ExRsData <= 32'd0;
      ExRtData <= 32'd0;
      ExImm    <= 32'd0;
      ExRs     <= 5'd0;
      ExRt     <= 5'd0;
      ExRd     <= 5'd0;
    end else if (Flush) begin
      state   <= RUN;
      cnt     <= 4'd0;
      busy    <= 1'b0;
      ExValid <= 1'b0;
      ExCtrl  <= 17'd0;
    end else if (state == MUL) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        state <= RUN;
        busy  <= 1'b0;
      end
    end else if (load_use) begin
      ExValid <= 1'b0;
      ExCtrl  <= 17'd0;
    end else begin
      ExValid  <= InValid;
      ExCtrl   <= CtrlIn;
      ExRsData <= RsData;
      ExRtData <= RtData;
      ExImm    <= Imm;
      ExRs     <= Rs;
      ExRt     <= Rt;
      ExRd     <= Rd;
      if (is_mul && MUL_MULTI) begin
        state <= MUL;
        cnt   <= CNT_INIT;
        busy  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, load-use, multiply hold,
// flush abort and asynchronous reset.
module tb_id_ex_stage;

`ifdef LOAD_USE_STALL_EN
  localparam bit LU = 1'b1;
`else
  localparam bit LU = 1'b0;
`endif

  // {RegDst,RegWrite,AluSrc,AluOp,MemWrite,MemRead,Branch,MemToReg,SignExt,Jump,JumpMux}
  localparam logic [16:0] C_ADD =
    {2'b01, 1'b1, 1'b0, 5'b00010, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
  localparam logic [16:0] C_ADDI =
    {2'b00, 1'b1, 1'b1, 5'b00010, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
  localparam logic [16:0] C_LW =
    {2'b00, 1'b1, 1'b1, 5'b00010, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};
  localparam logic [16:0] C_MUL =
    {2'b01, 1'b1, 1'b0, 5'b01100, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};

  logic        Clk = 1'b0;
  logic        Rst;
  logic        InValid;
  logic [16:0] CtrlIn;
  logic [31:0] RsData;
  logic [31:0] RtData;
  logic [31:0] Imm;
  logic [4:0]  Rs;
  logic [4:0]  Rt;
  logic [4:0]  Rd;
  logic        Flush;
  logic        Stall;
  logic        ExBusy;
  logic        ExValid;
  logic [16:0] ExCtrl;
  logic [31:0] ExRsData;
  logic [31:0] ExRtData;
  logic [31:0] ExImm;
  logic [4:0]  ExRs;
  logic [4:0]  ExRt;
  logic [4:0]  ExRd;

  int n_run  = 0;
  int n_fail = 0;

  id_ex_stage #(.MUL_CYCLES(4)) dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .CtrlIn(CtrlIn),
    .RsData(RsData), .RtData(RtData), .Imm(Imm),
    .Rs(Rs), .Rt(Rt), .Rd(Rd), .Flush(Flush),
    .Stall(Stall), .ExBusy(ExBusy), .ExValid(ExValid), .ExCtrl(ExCtrl),
    .ExRsData(ExRsData), .ExRtData(ExRtData), .ExImm(ExImm),
    .ExRs(ExRs), .ExRt(ExRt), .ExRd(ExRd)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [16:0] c,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] a);
    InValid = v;
    CtrlIn  = c;
    Rs      = rs;
    Rt      = rt;
    Rd      = rd;
    RsData  = a;
    RtData  = ~a;
    Imm     = {a[15:0], a[31:16]};
  endtask

  initial begin
    Rst   = 1'b0;
    Flush = 1'b0;
    drive(1'b1, C_ADD, 5'd1, 5'd2, 5'd3, 32'h1111_2222);
    #12;
    check("rst_valid", ExValid, 0);
    check("rst_ctrl", ExCtrl, 0);
    check("rst_rsdata", ExRsData, 0);
    check("rst_stall", Stall, 0);
    check("rst_busy", ExBusy, 0);

    // first capture after release
    tick();
    Rst = 1'b1;
    tick();
    check("cap_valid", ExValid, 1);
    check("cap_ctrl", ExCtrl, C_ADD);
    check("cap_rsdata", ExRsData, 32'h1111_2222);
    check("cap_rtdata", ExRtData, 32'heeee_dddd);
    check("cap_imm", ExImm, 32'h2222_1111);
    check("cap_rd", ExRd, 3);

    // LW r5 then ADD using r5 as Rs
    drive(1'b1, C_LW, 5'd1, 5'd5, 5'd5, 32'h0000_0100);
    tick();
    check("lw_ctrl", ExCtrl, C_LW);
    check("lw_rt", ExRt, 5);
    drive(1'b1, C_ADD, 5'd5, 5'd6, 5'd7, 32'h0000_0200);
    #1;
    check("lu_stall", Stall, LU);
    tick();
    check("lu_bubble_valid", ExValid, !LU);
    check("lu_bubble_ctrl", ExCtrl, LU ? 17'd0 : C_ADD);
    check("lu_bubble_rt", ExRt, LU ? 5'd5 : 5'd6);
    check("lu_after_stall", Stall, 0);
    tick();
    check("lu_add_valid", ExValid, 1);
    check("lu_add_ctrl", ExCtrl, C_ADD);
    check("lu_add_rd", ExRd, 7);

    // load to r0 never stalls
    drive(1'b1, C_LW, 5'd1, 5'd0, 5'd0, 32'h0000_0300);
    tick();
    drive(1'b1, C_ADD, 5'd0, 5'd6, 5'd8, 32'h0000_0400);
    #1;
    check("r0_stall", Stall, 0);
    tick();
    check("r0_add_rd", ExRd, 8);
    check("r0_add_valid", ExValid, 1);

    // ADDI reading r5 only through Rt field
    drive(1'b1, C_LW, 5'd1, 5'd5, 5'd5, 32'h0000_0500);
    tick();
    drive(1'b1, C_ADDI, 5'd7, 5'd5, 5'd5, 32'h0000_0600);
    #1;
    check("addi_stall", Stall, 0);
    tick();
    check("addi_ctrl", ExCtrl, C_ADDI);

    // invalid ID slot never stalls
    drive(1'b1, C_LW, 5'd1, 5'd5, 5'd5, 32'h0000_0700);
    tick();
    drive(1'b0, C_ADD, 5'd5, 5'd5, 5'd9, 32'h0000_0800);
    #1;
    check("inv_stall", Stall, 0);
    tick();
    check("inv_valid", ExValid, 0);

    // Rt match on a register-register op
    drive(1'b1, C_LW, 5'd1, 5'd5, 5'd5, 32'h0000_0900);
    tick();
    drive(1'b1, C_ADD, 5'd2, 5'd5, 5'd10, 32'h0000_0a00);
    #1;
    check("rt_stall", Stall, LU);
    tick();
    tick();
    check("rt_add_rd", ExRd, 10);

    // multiply occupies EX for four cycles
    drive(1'b1, C_MUL, 5'd3, 5'd4, 5'd11, 32'h0000_000a);
    tick();
    check("mul_ctrl", ExCtrl, C_MUL);
    drive(1'b1, C_ADD, 5'd1, 5'd2, 5'd12, 32'h0000_0b00);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("mul_busy%0d", i), ExBusy, 1);
      check($sformatf("mul_stall%0d", i), Stall, 1);
      check($sformatf("mul_hold%0d", i), ExRd, 11);
      tick();
    end
    check("mul_last_busy", ExBusy, 0);
    check("mul_last_stall", Stall, 0);
    check("mul_last_hold", ExRsData, 32'h0000_000a);
    tick();
    check("mul_next_rd", ExRd, 12);

    // flush in the second multiply cycle
    drive(1'b1, C_MUL, 5'd3, 5'd4, 5'd13, 32'h0000_000b);
    tick();
    drive(1'b1, C_ADD, 5'd1, 5'd2, 5'd14, 32'h0000_0c00);
    tick();
    check("fl_busy_pre", ExBusy, 1);
    Flush = 1'b1;
    #1;
    check("fl_stall", Stall, 0);
    tick();
    Flush = 1'b0;
    #1;
    check("fl_valid", ExValid, 0);
    check("fl_ctrl", ExCtrl, 0);
    check("fl_busy", ExBusy, 0);
    check("fl_stall_after", Stall, 0);
    tick();
    check("fl_next_rd", ExRd, 14);
    check("fl_next_valid", ExValid, 1);

    // asynchronous reset with two multiply cycles left
    drive(1'b1, C_MUL, 5'd3, 5'd4, 5'd15, 32'h0000_000c);
    tick();
    tick();
    check("ar_busy_pre", ExBusy, 1);
    Rst = 1'b0;
    #1;
    check("ar_valid", ExValid, 0);
    check("ar_ctrl", ExCtrl, 0);
    check("ar_rsdata", ExRsData, 0);
    check("ar_rd", ExRd, 0);
    check("ar_busy", ExBusy, 0);
    check("ar_stall", Stall, 0);
    #1;
    Rst = 1'b1;
    drive(1'b1, C_ADD, 5'd1, 5'd2, 5'd16, 32'h0000_0d00);
    tick();
    check("ar_cap_valid", ExValid, 1);
    check("ar_cap_rd", ExRd, 16);
    check("ar_cap_busy", ExBusy, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
